// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for eight requesters sharing one 8:1 mux path.
// Grants are registered; an owner is released on done, a dropped request, or hold expiry.
module bus_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  gnt_q, gnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [2:0]  last_q, last_d;

  logic [3:0]  pick_idle, pick_rel;
  logic        owner_req, hold_expired, release_now;

  // Returns {found, index} of the first set bit searching base+1 .. base+8 (mod 8).
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = base + 3'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    timeout_d    = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    last_d       = last_q;

    owner_req    = req[sel_q];
    hold_expired = (hold_cnt_q == 8'(MAX_HOLD - 1));
    release_now  = done || !owner_req || hold_expired;
    pick_idle    = rr_pick(req, last_q);
    // The departing owner is masked so a timed-out sole requester sees one idle cycle.
    pick_rel     = rr_pick(req & ~(8'(1) << sel_q), sel_q);

    case (state_q)
      IDLE: begin
        if (pick_idle[3]) begin
          state_d    = GRANT;
          gnt_d      = 8'(1) << pick_idle[2:0];
          sel_d      = pick_idle[2:0];
          busy_d     = 1'b1;
          hold_cnt_d = 8'd0;
          last_d     = pick_idle[2:0];
        end else begin
          gnt_d  = 8'd0;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_now) begin
          timeout_d = hold_expired && !done && owner_req;
          if (pick_rel[3]) begin
            gnt_d      = 8'(1) << pick_rel[2:0];
            sel_d      = pick_rel[2:0];
            busy_d     = 1'b1;
            hold_cnt_d = 8'd0;
            last_d     = pick_rel[2:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
            busy_d  = 1'b0;
          end
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 8'd0;
      sel_q      <= 3'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
      last_q     <= 3'd7;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Scoreboard bench for bus_arbiter8: stimulus queues the expected post-edge outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_bus_arbiter8;

  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;

  bus_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t e);
    exp_t a;
    a = '{gnt: gnt, sel: sel, busy: busy, timeout: timeout};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got gnt=%02h sel=%0d busy=%0b to=%0b, want gnt=%02h sel=%0d busy=%0b to=%0b",
               name, a.gnt, a.sel, a.busy, a.timeout, e.gnt, e.sel, e.busy, e.timeout);
    end else begin
      $display("ok   %s: gnt=%02h sel=%0d busy=%0b to=%0b", name, a.gnt, a.sel, a.busy, a.timeout);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vec++;
      check($sformatf("vec%0d", vec), e);
    end
  end

  task automatic expect_next(input logic [7:0] g, input logic [2:0] s,
                             input logic b, input logic t);
    exp_q.push_back('{gnt: g, sel: s, busy: b, timeout: t});
  endtask

  task automatic step(input logic [7:0] r, input logic d, input logic [7:0] g,
                      input logic [2:0] s, input logic b, input logic t);
    @(negedge clk);
    req  = r;
    done = d;
    expect_next(g, s, b, t);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int wait_cycles;
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    #2;
    check("reset_state", '{gnt: 8'h00, sel: 3'd0, busy: 1'b0, timeout: 1'b0});
    @(negedge clk);
    reset = 1'b0;

    // First grant after reset goes to requester 0
    step(8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Full rotation with done every cycle: 0..7 then 0, no idle gap
    pulse_reset();
    step(8'hFF, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      logic [2:0] ix;
      ix = 3'(i);
      step(8'hFF, 1'b1, 8'(1) << ix, ix, 1'b1, 1'b0);
    end
    step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Sole requester 2 timed out: 4 grant cycles, one idle cycle with timeout, re-grant
    step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    step(8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1);
    step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    // done coincides with hold expiry: plain release, no timeout
    step(8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);

    // Owner 3, requester 5 arrives (no preemption), then req[3] drops -> hand-off to 5
    step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    step(8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0);

    // done in IDLE is ignored
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0);

    // Timeout with another requester waiting: direct hand-off, timeout still pulses
    step(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
    step(8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1);
    step(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);

    // Asynchronous reset while owner is 6
    @(negedge clk);
    req   = 8'h40;
    reset = 1'b1;
    #1;
    check("async_reset", '{gnt: 8'h00, sel: 3'd0, busy: 1'b0, timeout: 1'b0});
    @(negedge clk);
    reset = 1'b0;
    req   = 8'hC1;
    expect_next(8'h01, 3'd0, 1'b1, 1'b0);

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 50) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
